// File: rtl/dwt_analysis_bank.sv
`default_nettype none
// ============================================================================
// Module   : dwt_analysis_bank
// Brief    : One-level Haar/db2 wavelet analysis over N_CH interleaved
//            channels; decimated lowpass/highpass with rounding + saturation.
// Revision : 1.0
// ============================================================================
module dwt_analysis_bank #(
  parameter int DATA_W    = 32,
  parameter int N_CH      = 8,
  parameter int MODE      = 0,
  parameter int COEF_FRAC = 13,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [DATA_W-1:0] out_lo,
  output logic [DATA_W-1:0] out_hi,
  output logic              out_sat
);

  localparam int c_TAPS  = (MODE == 1) ? 4 : 2;
  localparam int c_HIST  = c_TAPS - 1;
  localparam int c_DEPTH = 1 << CH_W;
  localparam int c_PW    = DATA_W + 16;
  localparam int c_SW    = DATA_W + 18;

  localparam logic signed [c_SW-1:0] c_RND =
    {{(c_SW-COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC-1){1'b0}}};
  localparam logic signed [c_SW-1:0] c_MAX =
    {{(c_SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [c_SW-1:0] c_MIN =
    {{(c_SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  if (MODE != 0 && MODE != 1) begin : g_bad_mode
    $error("dwt_analysis_bank: MODE must be 0 (Haar) or 1 (db2)");
  end

  // Q2.13 taps; index j multiplies x[n-j]
  function automatic logic signed [15:0] coef_lo(input int j);
    logic signed [15:0] c;
    c = '0;
    if (MODE == 1) begin
      case (j)
        0:       c = -16'sd1060;
        1:       c =  16'sd1836;
        2:       c =  16'sd6853;
        3:       c =  16'sd3957;
        default: c = '0;
      endcase
    end else begin
      case (j)
        0, 1:    c = 16'sd5793;
        default: c = '0;
      endcase
    end
    return c;
  endfunction

  function automatic logic signed [15:0] coef_hi(input int j);
    logic signed [15:0] c;
    c = '0;
    if (MODE == 1) begin
      case (j)
        0:       c = -16'sd3957;
        1:       c =  16'sd6853;
        2:       c = -16'sd1836;
        3:       c = -16'sd1060;
        default: c = '0;
      endcase
    end else begin
      case (j)
        0:       c = -16'sd5793;
        1:       c =  16'sd5793;
        default: c = '0;
      endcase
    end
    return c;
  endfunction

  // returns {clipped, value}
  function automatic logic [DATA_W:0] saturate(input logic signed [c_SW-1:0] v);
    if (v > c_MAX)      return {1'b1, c_MAX[DATA_W-1:0]};
    else if (v < c_MIN) return {1'b1, c_MIN[DATA_W-1:0]};
    else                return {1'b0, v[DATA_W-1:0]};
  endfunction

  // ---------------------------------------------------------------- input side
  logic [CH_W-1:0]          r_ch_cnt;
  logic [c_DEPTH-1:0]       r_phase;
  logic signed [DATA_W-1:0] r_hist [c_DEPTH][c_HIST];
  logic                     w_launch;

  assign w_launch = in_valid & r_phase[r_ch_cnt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch_cnt <= '0;
      r_phase  <= '0;
      for (int c = 0; c < c_DEPTH; c++)
        for (int k = 0; k < c_HIST; k++) r_hist[c][k] <= '0;
    end else if (clr) begin
      r_ch_cnt <= '0;
      r_phase  <= '0;
      for (int c = 0; c < c_DEPTH; c++)
        for (int k = 0; k < c_HIST; k++) r_hist[c][k] <= '0;
    end else if (in_valid) begin
      r_hist[r_ch_cnt][0] <= in_data;
      for (int k = 1; k < c_HIST; k++) r_hist[r_ch_cnt][k] <= r_hist[r_ch_cnt][k-1];
      r_phase[r_ch_cnt] <= ~r_phase[r_ch_cnt];
      r_ch_cnt <= (r_ch_cnt == CH_W'(N_CH - 1)) ? '0 : r_ch_cnt + 1'b1;
    end
  end

  // ------------------------------------------------- stage 0: tap snapshot
  logic                     r_v0;
  logic [CH_W-1:0]          r_ch0;
  logic signed [DATA_W-1:0] r_tap [c_TAPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v0  <= 1'b0;
      r_ch0 <= '0;
      for (int j = 0; j < c_TAPS; j++) r_tap[j] <= '0;
    end else if (clr) begin
      r_v0  <= 1'b0;
      r_ch0 <= '0;
      for (int j = 0; j < c_TAPS; j++) r_tap[j] <= '0;
    end else begin
      r_v0 <= w_launch;
      if (w_launch) begin
        r_ch0    <= r_ch_cnt;
        r_tap[0] <= in_data;
        for (int j = 1; j < c_TAPS; j++) r_tap[j] <= r_hist[r_ch_cnt][j-1];
      end
    end
  end

  // ----------------------------------------------------- stage 1: products
  logic                   r_v1;
  logic [CH_W-1:0]        r_ch1;
  logic signed [c_PW-1:0] r_plo [c_TAPS];
  logic signed [c_PW-1:0] r_phi [c_TAPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_ch1 <= '0;
      for (int j = 0; j < c_TAPS; j++) begin
        r_plo[j] <= '0;
        r_phi[j] <= '0;
      end
    end else if (clr) begin
      r_v1  <= 1'b0;
      r_ch1 <= '0;
      for (int j = 0; j < c_TAPS; j++) begin
        r_plo[j] <= '0;
        r_phi[j] <= '0;
      end
    end else begin
      r_v1 <= r_v0;
      if (r_v0) begin
        r_ch1 <= r_ch0;
        for (int j = 0; j < c_TAPS; j++) begin
          r_plo[j] <= r_tap[j] * coef_lo(j);
          r_phi[j] <= r_tap[j] * coef_hi(j);
        end
      end
    end
  end

  // ---------------------------------- stage 2: sum, round, shift, saturate
  logic signed [c_SW-1:0] w_sum_lo, w_sum_hi;
  logic signed [c_SW-1:0] w_shf_lo, w_shf_hi;
  logic [DATA_W:0]        w_sat_lo, w_sat_hi;

  always_comb begin
    w_sum_lo = '0;
    w_sum_hi = '0;
    for (int j = 0; j < c_TAPS; j++) begin
      w_sum_lo = w_sum_lo + r_plo[j];
      w_sum_hi = w_sum_hi + r_phi[j];
    end
    w_shf_lo = (w_sum_lo + c_RND) >>> COEF_FRAC;
    w_shf_hi = (w_sum_hi + c_RND) >>> COEF_FRAC;
    w_sat_lo = saturate(w_shf_lo);
    w_sat_hi = saturate(w_shf_hi);
  end

  // outputs hold between strobes; only the strobe itself is a pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_lo    <= '0;
      out_hi    <= '0;
      out_sat   <= 1'b0;
    end else if (clr) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_lo    <= '0;
      out_hi    <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= r_v1;
      if (r_v1) begin
        out_ch  <= r_ch1;
        out_lo  <= w_sat_lo[DATA_W-1:0];
        out_hi  <= w_sat_hi[DATA_W-1:0];
        out_sat <= w_sat_lo[DATA_W] | w_sat_hi[DATA_W];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dwt_analysis_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_dwt_analysis_bank
// Brief    : Scoreboard bench for Haar(N_CH=1), db2(N_CH=1), Haar(N_CH=2).
// Revision : 1.0
// ============================================================================
module tb_dwt_analysis_bank;

  typedef struct {
    int          id;
    int          due;
    logic        ch;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        iv  [3];
  logic [31:0] idat[3];
  logic        ov  [3];
  logic [0:0]  och [3];
  logic [31:0] olo [3];
  logic [31:0] ohi [3];
  logic        osat[3];

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  exp_t sb[$];

  // reference state per instance
  int          c_mode[3] = '{0, 1, 0};
  int          c_nch [3] = '{1, 1, 2};
  logic [31:0] mh [3][2][3];
  bit          mph[3][2];
  int          mch[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dwt_analysis_bank #(.DATA_W(32), .N_CH(1), .MODE(0), .COEF_FRAC(13)) u_haar1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(iv[0]), .in_data(idat[0]),
    .out_valid(ov[0]), .out_ch(och[0]), .out_lo(olo[0]), .out_hi(ohi[0]), .out_sat(osat[0]));

  dwt_analysis_bank #(.DATA_W(32), .N_CH(1), .MODE(1), .COEF_FRAC(13)) u_db2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(iv[1]), .in_data(idat[1]),
    .out_valid(ov[1]), .out_ch(och[1]), .out_lo(olo[1]), .out_hi(ohi[1]), .out_sat(osat[1]));

  dwt_analysis_bank #(.DATA_W(32), .N_CH(2), .MODE(0), .COEF_FRAC(13)) u_haar2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(iv[2]), .in_data(idat[2]),
    .out_valid(ov[2]), .out_ch(och[2]), .out_lo(olo[2]), .out_hi(ohi[2]), .out_sat(osat[2]));

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] clamp(input longint v);
    if (v > 64'sd2147483647)       return {1'b1, 32'h7FFF_FFFF};
    else if (v < -64'sd2147483648) return {1'b1, 32'h8000_0000};
    else                           return {1'b0, v[31:0]};
  endfunction

  function automatic void ref_calc(input int mode, input logic [31:0] t0, t1, t2, t3,
                                   output logic [31:0] lo, output logic [31:0] hi,
                                   output logic sat);
    longint x[4], cl[4], ch[4], sl, sh;
    logic [32:0] rl, rh;
    x[0] = $signed(t0); x[1] = $signed(t1); x[2] = $signed(t2); x[3] = $signed(t3);
    if (mode == 1) begin
      cl = '{-1060, 1836, 6853, 3957};
      ch = '{-3957, 6853, -1836, -1060};
    end else begin
      cl = '{5793, 5793, 0, 0};
      ch = '{-5793, 5793, 0, 0};
    end
    sl = 0; sh = 0;
    for (int j = 0; j < 4; j++) begin
      sl += cl[j] * x[j];
      sh += ch[j] * x[j];
    end
    rl = clamp((sl + 4096) >>> 13);
    rh = clamp((sh + 4096) >>> 13);
    lo = rl[31:0]; hi = rh[31:0]; sat = rl[32] | rh[32];
  endfunction

  task automatic clear_model();
    sb.delete();
    for (int d = 0; d < 3; d++) begin
      mch[d] = 0;
      for (int c = 0; c < 2; c++) begin
        mph[d][c] = 1'b0;
        for (int k = 0; k < 3; k++) mh[d][c][k] = '0;
      end
    end
  endtask

  // Called aligned 1 time unit after a rising edge; returns aligned the same way.
  task automatic drive(input int id, input logic [31:0] x, input bit fix,
                       input logic [31:0] elo, input logic [31:0] ehi, input logic esat);
    int ch;
    exp_t e;
    ch = mch[id];
    if (mph[id][ch]) begin
      e.id = id; e.due = cyc + 3; e.ch = ch[0];
      ref_calc(c_mode[id], x, mh[id][ch][0], mh[id][ch][1], mh[id][ch][2], e.lo, e.hi, e.sat);
      if (fix) begin e.lo = elo; e.hi = ehi; e.sat = esat; end
      sb.push_back(e);
    end
    mh[id][ch][2] = mh[id][ch][1];
    mh[id][ch][1] = mh[id][ch][0];
    mh[id][ch][0] = x;
    mph[id][ch]   = ~mph[id][ch];
    mch[id]       = (ch + 1) % c_nch[id];
    iv[id] = 1'b1; idat[id] = x;
    @(posedge clk); #1;
    iv[id] = 1'b0;
  endtask

  task automatic drv(input int id, input logic [31:0] x);
    drive(id, x, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic drvx(input int id, input logic [31:0] x, input logic [31:0] lo,
                      input logic [31:0] hi, input logic sat);
    drive(id, x, 1'b1, lo, hi, sat);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    clear_model();
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    int   idx;
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (ov[d] === 1'b1) begin
        idx = -1;
        for (int i = 0; i < sb.size(); i++)
          if (idx < 0 && sb[i].id == d) idx = i;
        if (idx < 0) begin
          chk_eq($sformatf("spurious_strobe_dut%0d", d), 1, 0);
        end else begin
          e = sb[idx];
          sb.delete(idx);
          chk_eq($sformatf("strobe_cycle_dut%0d", d), cyc, e.due);
          chk_eq($sformatf("out_ch_dut%0d", d), och[d], e.ch);
          chk_eq($sformatf("out_lo_dut%0d", d), olo[d], e.lo);
          chk_eq($sformatf("out_hi_dut%0d", d), ohi[d], e.hi);
          chk_eq($sformatf("out_sat_dut%0d", d), osat[d], e.sat);
        end
      end
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due < cyc) begin
        chk_eq($sformatf("missing_strobe_dut%0d", sb[i].id), cyc, sb[i].due);
        sb.delete(i);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, observed running, expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin iv[d] = 1'b0; idat[d] = '0; end
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk_eq($sformatf("rst_valid_dut%0d", d), ov[d], 0);
      chk_eq($sformatf("rst_ch_dut%0d", d), och[d], 0);
      chk_eq($sformatf("rst_lo_dut%0d", d), olo[d], 0);
      chk_eq($sformatf("rst_hi_dut%0d", d), ohi[d], 0);
      chk_eq($sformatf("rst_sat_dut%0d", d), osat[d], 0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Haar basic pair, then confirm outputs hold
    drv (0, 32'h2000_0000);
    drvx(0, 32'h2000_0000, 32'h2D42_0000, 32'h0, 1'b0);
    idle(5);
    chk_eq("hold_lo", olo[0], 32'h2D42_0000);
    chk_eq("hold_valid", ov[0], 0);

    // Haar round-half-up
    drv (0, 32'd1);
    drvx(0, 32'd0, 32'd1, 32'd1, 1'b0);
    drv (0, 32'hFFFF_FFFF);
    drvx(0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    idle(5);

    // db2 full-scale constant: first output unsaturated, rest clip
    for (int i = 0; i < 8; i++) begin
      if (i == 1)     drvx(1, 32'h7FFF_FFFF, 32'h0C20_0000, 32'h2D40_0000, 1'b0);
      else if (i & 1) drvx(1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0, 1'b1);
      else            drv (1, 32'h7FFF_FFFF);
    end
    idle(5);

    // two interleaved channels, back-to-back
    drv (2, 32'd100);
    drv (2, -32'sd200);
    drvx(2, 32'd300,  32'd283,  -32'sd141, 1'b0);
    drvx(2, -32'sd600, -32'sd566, 32'd283,  1'b0);
    idle(5);

    // clr right after a launching sample, then clean pair
    drv(0, 32'h1234_5678);
    drv(0, 32'h0ABC_DEF0);
    clr_pulse();
    drv (0, 32'h2000_0000);
    drvx(0, 32'h2000_0000, 32'h2D42_0000, 32'h0, 1'b0);
    idle(5);
    // clr after a lone phase-0 sample
    drv(0, 32'h4000_0000);
    idle(1);
    clr_pulse();
    drv (0, 32'h2000_0000);
    drvx(0, 32'h2000_0000, 32'h2D42_0000, 32'h0, 1'b0);
    idle(5);
    // db2 history must be cleared too
    drv(1, 32'h5A5A_5A5A);
    drv(1, 32'h3333_3333);
    drv(1, 32'h7000_0000);
    clr_pulse();
    for (int i = 0; i < 6; i++) drv(1, 32'h2000_0000 + 32'(i * 32'h0100_0000));
    idle(5);
    // two-channel: orphan on ch0, then clr must restart at ch0
    drv(2, 32'd777);
    clr_pulse();
    for (int i = 0; i < 8; i++) drv(2, $urandom_range(0, 32'h00FF_FFFF));
    idle(5);

    // random streams (db2 back-to-back, full range; two-channel with gaps)
    for (int i = 0; i < 40; i++) drv(1, $urandom);
    idle(5);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      drv(2, $urandom);
    end
    idle(6);

    // asynchronous reset with a compute in flight
    drv(0, 32'h1111_1111);
    drv(0, 32'h2222_2222);
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    chk_eq("arst_valid", ov[0], 0);
    chk_eq("arst_ch", och[0], 0);
    chk_eq("arst_lo", olo[0], 0);
    chk_eq("arst_hi", ohi[0], 0);
    chk_eq("arst_sat", osat[0], 0);
    chk_eq("arst_lo_db2", olo[1], 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    drv (0, 32'h2000_0000);
    drvx(0, 32'h2000_0000, 32'h2D42_0000, 32'h0, 1'b0);
    idle(6);

    chk_eq("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
